// File: rtl/jpeg_bit_unpacker.sv
// jpeg_bit_unpacker: entropy-coded-segment front end. Takes scan bytes, removes
// 0xFF00 stuffing, detects markers (skipping 0xFF fill bytes) and serialises
// data MSB-first, one bit per request, toward the Huffman decoder.
module jpeg_bit_unpacker (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    output logic       byte_ready,
    input  logic       bit_req,
    input  logic       marker_clear,
    output logic       next_bit,
    output logic       is_new,
    output logic       marker_found,
    output logic [7:0] marker_code,
    output logic       bits_avail
);

    typedef enum logic [1:0] {
        StShift,
        StFfWait,
        StMarker
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic        next_bit_q, next_bit_d;
    logic        is_new_q, is_new_d;
    logic        marker_found_q, marker_found_d;
    logic [7:0]  marker_code_q, marker_code_d;

    logic        serve;
    logic        xfer;

    // Handshake and bit-serve qualifiers. A byte may load in the same cycle the
    // last held bit leaves, which keeps the bit stream gap-free across bytes.
    always_comb begin
        byte_ready = 1'b0;
        unique case (state_q)
            StShift:  byte_ready = (bit_cnt_q == 4'd0) || ((bit_cnt_q == 4'd1) && bit_req);
            StFfWait: byte_ready = 1'b1;
            StMarker: byte_ready = 1'b0;
            default:  byte_ready = 1'b0;
        endcase
        serve = (state_q == StShift) && bit_req && (bit_cnt_q != 4'd0);
        xfer  = byte_valid && byte_ready;
    end

    // Next-state: bit serving, byte loading, stuffing/fill/marker decode.
    always_comb begin
        state_d        = state_q;
        shreg_d        = shreg_q;
        bit_cnt_d      = bit_cnt_q;
        next_bit_d     = next_bit_q;
        is_new_d       = 1'b0;
        marker_found_d = marker_found_q;
        marker_code_d  = marker_code_q;

        unique case (state_q)
            StShift: begin
                if (serve) begin
                    next_bit_d = shreg_q[7];
                    is_new_d   = 1'b1;
                    shreg_d    = {shreg_q[6:0], 1'b0};
                    bit_cnt_d  = bit_cnt_q - 4'd1;
                end
                if (xfer) begin
                    if (byte_in != 8'hFF) begin
                        shreg_d   = byte_in;
                        bit_cnt_d = 4'd8;
                    end else begin
                        // Hold off loading 0xFF until the following byte says
                        // whether it is stuffed data or a marker prefix.
                        bit_cnt_d = 4'd0;
                        state_d   = StFfWait;
                    end
                end
            end
            StFfWait: begin
                if (xfer) begin
                    if (byte_in == 8'h00) begin
                        shreg_d   = 8'hFF;
                        bit_cnt_d = 4'd8;
                        state_d   = StShift;
                    end else if (byte_in != 8'hFF) begin
                        marker_code_d  = byte_in;
                        marker_found_d = 1'b1;
                        state_d        = StMarker;
                    end
                    // 0xFF here is a fill byte: keep waiting for the marker code.
                end
            end
            StMarker: begin
                if (marker_clear) begin
                    marker_found_d = 1'b0;
                    bit_cnt_d      = 4'd0;
                    state_d        = StShift;
                end
            end
            default: state_d = StShift;
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= StShift;
            shreg_q        <= 8'h00;
            bit_cnt_q      <= 4'd0;
            next_bit_q     <= 1'b0;
            is_new_q       <= 1'b0;
            marker_found_q <= 1'b0;
            marker_code_q  <= 8'h00;
        end else begin
            state_q        <= state_d;
            shreg_q        <= shreg_d;
            bit_cnt_q      <= bit_cnt_d;
            next_bit_q     <= next_bit_d;
            is_new_q       <= is_new_d;
            marker_found_q <= marker_found_d;
            marker_code_q  <= marker_code_d;
        end
    end

    assign next_bit     = next_bit_q;
    assign is_new       = is_new_q;
    assign marker_found = marker_found_q;
    assign marker_code  = marker_code_q;
    assign bits_avail   = (bit_cnt_q != 4'd0);

endmodule

// File: tb/tb_jpeg_bit_unpacker.sv
// Bench for jpeg_bit_unpacker: byte-level destuffing model plus directed vectors.
module tb_jpeg_bit_unpacker;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] byte_in = 8'h00;
    logic       byte_valid = 1'b0;
    logic       byte_ready;
    logic       bit_req = 1'b0;
    logic       marker_clear = 1'b0;
    logic       next_bit;
    logic       is_new;
    logic       marker_found;
    logic [7:0] marker_code;
    logic       bits_avail;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    jpeg_bit_unpacker dut (
        .clk          (clk),
        .rst          (rst),
        .byte_in      (byte_in),
        .byte_valid   (byte_valid),
        .byte_ready   (byte_ready),
        .bit_req      (bit_req),
        .marker_clear (marker_clear),
        .next_bit     (next_bit),
        .is_new       (is_new),
        .marker_found (marker_found),
        .marker_code  (marker_code),
        .bits_avail   (bits_avail)
    );

    // Byte source and model state.
    logic [7:0] src_q[$];
    bit         exp_q[$];     // destuffed bits already handed to the DUT, not yet served
    bit         pend_ff   = 1'b0;
    bit         in_marker = 1'b0;
    logic [7:0] exp_code  = 8'h00;
    bit         exp_nb    = 1'b0;
    int         cyc       = 0;

    // Observed bit log for directed checks.
    logic [31:0] got_bits = 32'h0;
    int          got_n    = 0;
    int          got_cyc[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at t=%0t", name, act, req, $time);
        end
    endtask

    task automatic refresh_src();
        byte_valid = (src_q.size() != 0);
        byte_in    = byte_valid ? src_q[0] : 8'h00;
    endtask

    task automatic push_byte(input logic [7:0] b);
        src_q.push_back(b);
        refresh_src();
    endtask

    task automatic clr_got();
        got_bits = 32'h0;
        got_n    = 0;
        got_cyc.delete();
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reset wipes the model and the source, mirroring the loss of a partial byte.
    always @(posedge rst) begin
        exp_q.delete();
        src_q.delete();
        pend_ff   = 1'b0;
        in_marker = 1'b0;
        exp_code  = 8'h00;
        exp_nb    = 1'b0;
        refresh_src();
    end

    // Per-cycle compare against the byte-level model.
    always @(posedge clk) begin
        bit         s_req, s_valid, s_ready, s_clear, serve, xfer, exp_ready, exp_new;
        logic [7:0] s_byte;
        s_req   = bit_req;
        s_valid = byte_valid;
        s_ready = byte_ready;
        s_clear = marker_clear;
        s_byte  = byte_in;
        #1;
        if (!rst) begin
            cyc++;
            // Ready: never in a marker, always while resolving 0xFF, else when the
            // held bits are gone or the last one leaves this cycle.
            if (in_marker)    exp_ready = 1'b0;
            else if (pend_ff) exp_ready = 1'b1;
            else exp_ready = (exp_q.size() == 0) || (exp_q.size() == 1 && s_req);
            check("byte_ready", {31'b0, s_ready}, {31'b0, exp_ready});

            serve   = s_req && !in_marker && !pend_ff && (exp_q.size() != 0);
            exp_new = serve;
            if (serve) exp_nb = exp_q.pop_front();

            xfer = s_valid && s_ready;
            if (xfer) begin
                void'(src_q.pop_front());
                if (pend_ff) begin
                    if (s_byte == 8'h00) begin
                        for (int i = 7; i >= 0; i--) exp_q.push_back(1'b1);
                        pend_ff = 1'b0;
                    end else if (s_byte != 8'hFF) begin
                        in_marker = 1'b1;
                        exp_code  = s_byte;
                        pend_ff   = 1'b0;
                        exp_q.delete();
                    end
                end else if (s_byte == 8'hFF) begin
                    pend_ff = 1'b1;
                end else begin
                    for (int i = 7; i >= 0; i--) exp_q.push_back(s_byte[i]);
                end
            end
            if (s_clear && in_marker) begin
                in_marker = 1'b0;
                exp_q.delete();
            end

            check("is_new", {31'b0, is_new}, {31'b0, exp_new});
            check("next_bit", {31'b0, next_bit}, {31'b0, exp_nb});
            check("bits_avail", {31'b0, bits_avail}, {31'b0, exp_q.size() != 0});
            check("marker_found", {31'b0, marker_found}, {31'b0, in_marker});
            check("marker_code", {24'b0, marker_code}, {24'b0, exp_code});

            if (is_new) begin
                got_bits = {got_bits[30:0], next_bit};
                got_n++;
                got_cyc.push_back(cyc);
            end
            refresh_src();
        end
    end

    initial begin
        rst = 1'b1;
        run(2);
        check("rst_is_new", {31'b0, is_new}, 32'd0);
        check("rst_byte_ready", {31'b0, byte_ready}, 32'd1);
        check("rst_bits_avail", {31'b0, bits_avail}, 32'd0);
        check("rst_marker_code", {24'b0, marker_code}, 32'h0);
        rst = 1'b0;
        run(1);

        // Single byte 0xA5.
        clr_got();
        bit_req = 1'b1;
        push_byte(8'hA5);
        run(12);
        check("a5_count", got_n, 8);
        check("a5_bits", {24'b0, got_bits[7:0]}, 32'hA5);
        check("a5_consec", got_cyc[7] - got_cyc[0], 7);

        // Back-to-back 0x3C 0xC3, no gap across the byte boundary.
        clr_got();
        push_byte(8'h3C);
        push_byte(8'hC3);
        run(20);
        check("3cc3_count", got_n, 16);
        check("3cc3_bits", {16'b0, got_bits[15:0]}, 32'h3CC3);
        check("3cc3_consec", got_cyc[15] - got_cyc[0], 15);

        // Stuffed 0xFF00 then 0x80.
        clr_got();
        push_byte(8'hFF);
        push_byte(8'h00);
        push_byte(8'h80);
        run(24);
        check("stuff_count", got_n, 16);
        check("stuff_bits", {16'b0, got_bits[15:0]}, 32'hFF80);
        check("stuff_no_marker", {31'b0, marker_found}, 32'd0);

        // Data, fill byte, EOI marker; a queued byte must wait for the clear.
        clr_got();
        push_byte(8'h12);
        push_byte(8'hFF);
        push_byte(8'hFF);
        push_byte(8'hD9);
        push_byte(8'h55);
        run(18);
        check("mk_count", got_n, 8);
        check("mk_bits", {24'b0, got_bits[7:0]}, 32'h12);
        check("mk_found", {31'b0, marker_found}, 32'd1);
        check("mk_code", {24'b0, marker_code}, 32'hD9);
        check("mk_ready", {31'b0, byte_ready}, 32'd0);
        run(4);
        check("mk_no_bits", got_n, 8);
        marker_clear = 1'b1;
        run(1);
        marker_clear = 1'b0;
        check("mk_cleared", {31'b0, marker_found}, 32'd0);
        run(12);
        check("mk_after_count", got_n, 16);
        check("mk_after_bits", {24'b0, got_bits[7:0]}, 32'h55);

        // Gapped requests on 0x81.
        bit_req = 1'b0;
        clr_got();
        push_byte(8'h81);
        run(3);
        for (int i = 0; i < 8; i++) begin
            bit_req = 1'b1;
            run(1);
            bit_req = 1'b0;
            run(2);
        end
        check("gap_count", got_n, 8);
        check("gap_bits", {24'b0, got_bits[7:0]}, 32'h81);
        check("gap_spacing", got_cyc[7] - got_cyc[0], 21);

        // Asynchronous reset mid-byte.
        clr_got();
        push_byte(8'hF0);
        run(2);
        bit_req = 1'b1;
        run(3);
        bit_req = 1'b0;
        check("rb_partial", {29'b0, got_bits[2:0]}, 32'h7);
        #2;
        rst = 1'b1;
        #1;
        check("rb_is_new", {31'b0, is_new}, 32'd0);
        check("rb_next_bit", {31'b0, next_bit}, 32'd0);
        check("rb_bits_avail", {31'b0, bits_avail}, 32'd0);
        check("rb_byte_ready", {31'b0, byte_ready}, 32'd1);
        check("rb_marker", {31'b0, marker_found}, 32'd0);
        run(1);
        rst = 1'b0;
        run(1);
        clr_got();
        bit_req = 1'b1;
        push_byte(8'h0F);
        run(12);
        check("rb_count", got_n, 8);
        check("rb_bits", {24'b0, got_bits[7:0]}, 32'h0F);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
